uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

- Transmit-side framer for the team's UART.
- Accepts a parallel byte with a one-cycle valid strobe, then serialises it onto a single line, LSB first: start bit, data bits, optional parity bit, one stop bit.
- Runs at the baud clock: one bit per `clk` cycle. Bit timing is generated upstream.
- It is the counterpart of the RX deserializer/checker chain. Frames it emits must pass the RX start, parity and stop checks.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload bits per frame.

Ports:
- `clk`  in  1  baud-rate clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `P_DATA`  in  DATA_WIDTH  parallel payload; sampled only when accepted.
- `DATA_VALID`  in  1  single-cycle request strobe.
- `PAR_EN`  in  1  1 = insert parity bit; sampled with `P_DATA`.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled with `P_DATA`.
- `TX_OUT`  out  1  serial line, registered; idles high.
- `BUSY`  out  1  high while a frame is on the line (START..STOP).
- `RDY`  out  1  high when `DATA_VALID` will be accepted this cycle.

## Operation
FSM states: IDLE, START, DATA, PARITY, STOP.
- **Accept:** a request is accepted when `DATA_VALID && RDY`. On acceptance, latch `P_DATA`, `PAR_EN` and `PAR_TYP` into a frame register. Later input changes do not affect the frame in flight.
- **IDLE → START:** on acceptance. `TX_OUT`=1 in IDLE.
- **START:** `TX_OUT`=0 for 1 cycle, then go to DATA.
- **DATA:** `TX_OUT`=frame[bit_cnt], starting with bit_cnt = 0.
  - `bit_cnt` is a `$clog2(DATA_WIDTH)`-bit counter.
  - After bit `DATA_WIDTH-1`, go to PARITY if the latched PAR_EN = 1, otherwise to STOP.
  - `bit_cnt` clears on leaving DATA.
- **PARITY:** `TX_OUT` = (^frame) ^ latched PAR_TYP for 1 cycle, then go to STOP. Parity is computed from the latched byte, not from `P_DATA`.
- **STOP:** `TX_OUT`=1 for 1 cycle, then go to IDLE (see Configuration for the back-to-back path).
- **Frame length:** `DATA_WIDTH`+2 cycles, or +3 with parity.
- **BUSY:** 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **RDY** (base build): 1 only in IDLE. `DATA_VALID` while `RDY`=0 is dropped silently, with no effect on state.
- **Simultaneous events:** `DATA_VALID` in the STOP cycle (base build) is dropped. `DATA_VALID` in the first IDLE cycle after STOP is accepted.

## Timing
- **Reset values:** `TX_OUT`=1, `BUSY`=0, `RDY`=1; state=IDLE; bit_cnt=0; frame register=0.
- **Reset mid-frame:** the cycle after `rst` is sampled high, `TX_OUT`=1 and `BUSY`=0. The frame is aborted and never resumed. Any held byte is discarded.
- **Latency:** `DATA_VALID` sampled at edge N → start bit on `TX_OUT` from edge N through N+1, with `BUSY`=1 over the same interval.
- **Data/parity/stop:** data bit k is driven from edge N+1+k. Parity, if enabled, follows at N+1+DATA_WIDTH. The stop bit follows immediately after.
- **Base-build spacing:** at least one IDLE cycle (`TX_OUT`=1) separates consecutive frames.
- **Glitch-free line:** `TX_OUT` comes straight from a flop. It changes only on `clk` rising edges.

## Configuration
Macro: `UART_TX_HOLD_REG_EN`.
- **Defined:** adds a one-entry holding register (payload, PAR_EN, PAR_TYP, full flag).
  - `RDY` = !hold_full, so requests are accepted during a frame.
  - Acceptance while IDLE launches directly; the hold register is bypassed.
  - Acceptance while `BUSY` fills the hold register.
  - At the end of STOP with hold_full=1: go to START next cycle with no idle gap. The held entry moves to the frame register and hold_full clears.
  - `DATA_VALID` in the STOP cycle with hold empty is accepted and launches back-to-back the same way.
  - `DATA_VALID` while hold_full=1 is dropped.
- **Undefined:** no holding register, and `RDY` = (state==IDLE). All base-build rules above apply.

## Test plan
- Reset, then `P_DATA`=0xA5 with `PAR_EN`=0 → `TX_OUT` reads 0,1,0,1,0,0,1,0,1,1 (10 cycles). `BUSY` is high for exactly those 10 cycles.
- 0xA5 with `PAR_EN`=1: `PAR_TYP`=0 gives parity bit 0; `PAR_TYP`=1 gives parity bit 1. 0x00 with odd parity gives parity 1. Frame length is 11 cycles in each case.
- Base build: 0x3C accepted, then `DATA_VALID` with 0xFF in DATA and again in STOP → both dropped. Only the 0x3C frame appears, and the line returns to 1.
- Change `P_DATA`/`PAR_TYP` mid-frame → the transmitted bits and parity match the values latched at acceptance.
- Assert `rst` during data bit 3 → next cycle `TX_OUT`=1 and `BUSY`=0. A new 0x81 request then produces a complete, correct frame.
- `UART_TX_HOLD_REG_EN`: 0x12, then 0x34 accepted during the first frame → the second start bit immediately follows the first stop bit. `RDY` is low from acceptance of 0x34 until its transfer out of hold; a third request in that window is dropped.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - request/line signal bundle between a UART TX client and the framer
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  RDY;
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  RDY, TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output RDY, TX_OUT, BUSY
    );
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer (start, LSB-first data, optional parity, stop)
// Define UART_TX_HOLD_REG_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_frame_if.slave tx
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         next_cnt;
    logic [DATA_WIDTH-1:0] frame;
    logic                  frame_par_en;
    logic                  frame_par_typ;
    logic                  tx_out;
    logic                  busy;
    logic                  rdy;
    logic                  accept;
    logic                  launch;
    logic [DATA_WIDTH-1:0] launch_data;
    logic                  launch_par_en;
    logic                  launch_par_typ;

`ifdef UART_TX_HOLD_REG_EN
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_par_en;
    logic                  hold_par_typ;
    logic                  hold_full;

    assign rdy    = !hold_full;
    assign accept = tx.DATA_VALID && rdy;

    // A held entry has priority at the end of STOP; otherwise a request in IDLE/STOP bypasses the hold.
    always_comb begin
        launch         = 1'b0;
        launch_data    = tx.P_DATA;
        launch_par_en  = tx.PAR_EN;
        launch_par_typ = tx.PAR_TYP;
        if (state == STOP && hold_full) begin
            launch         = 1'b1;
            launch_data    = hold_data;
            launch_par_en  = hold_par_en;
            launch_par_typ = hold_par_typ;
        end else if ((state == IDLE || state == STOP) && accept) begin
            launch = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full    <= 1'b0;
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
        end else if (state == STOP && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept && !launch) begin
            hold_full    <= 1'b1;
            hold_data    <= tx.P_DATA;
            hold_par_en  <= tx.PAR_EN;
            hold_par_typ <= tx.PAR_TYP;
        end
    end
`else
    assign rdy    = (state == IDLE);
    assign accept = tx.DATA_VALID && rdy;

    always_comb begin
        launch         = accept;
        launch_data    = tx.P_DATA;
        launch_par_en  = tx.PAR_EN;
        launch_par_typ = tx.PAR_TYP;
    end
`endif

    assign next_cnt = bit_cnt + 1'b1;

    // tx_out is loaded with the value of the state being entered, so the line is a plain flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            frame         <= '0;
            frame_par_en  <= 1'b0;
            frame_par_typ <= 1'b0;
            tx_out        <= 1'b1;
            busy          <= 1'b0;
        end else if (launch) begin
            state         <= START;
            bit_cnt       <= '0;
            frame         <= launch_data;
            frame_par_en  <= launch_par_en;
            frame_par_typ <= launch_par_typ;
            tx_out        <= 1'b0;
            busy          <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx_out  <= frame[0];
                end
                DATA: begin
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        bit_cnt <= '0;
                        if (frame_par_en) begin
                            state  <= PARITY;
                            tx_out <= (^frame) ^ frame_par_typ;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= next_cnt;
                        tx_out  <= frame[next_cnt];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end
                STOP: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign tx.TX_OUT = tx_out;
    assign tx.BUSY   = busy;
    assign tx.RDY    = rdy;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame (queue-based line model plus literal frames)
module tb_uart_tx_frame;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();
    uart_tx_frame #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .tx(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: queue of line values still to appear, one entry per cycle, head = current cycle.
    bit            q[$];
    bit            model_valid = 1'b0;
    bit            m_hold_full = 1'b0;
    logic [DW-1:0] m_hold_d;
    bit            m_hold_pen;
    bit            m_hold_ptyp;
    logic          hist[$];
    logic          bhist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp);
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(d[i]);
        if (pen) q.push_back((($countones(d) % 2) == 1) ^ ptyp);
        q.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        int pre;
        bit mrdy;
        bit acc;
        if (rst) begin
            q.delete();
            m_hold_full = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            pre = q.size();
`ifdef UART_TX_HOLD_REG_EN
            mrdy = !m_hold_full;
`else
            mrdy = (pre == 0);
`endif
            acc = (bus.DATA_VALID === 1'b1) && mrdy;
            if (pre > 0) void'(q.pop_front());
`ifdef UART_TX_HOLD_REG_EN
            if (pre == 1 && m_hold_full) begin
                push_frame(m_hold_d, m_hold_pen, m_hold_ptyp);
                m_hold_full = 1'b0;
            end
            if (acc) begin
                if (pre <= 1) begin
                    push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
                end else begin
                    m_hold_full = 1'b1;
                    m_hold_d    = bus.P_DATA;
                    m_hold_pen  = bus.PAR_EN;
                    m_hold_ptyp = bus.PAR_TYP;
                end
            end
`else
            if (acc) push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
`endif
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_tx_out", bus.TX_OUT, (q.size() != 0) ? q[0] : 1'b1);
            chk("model_busy", bus.BUSY, q.size() != 0);
`ifdef UART_TX_HOLD_REG_EN
            chk("model_rdy", bus.RDY, !m_hold_full);
`else
            chk("model_rdy", bus.RDY, q.size() == 0);
`endif
        end
    end

    always @(posedge clk) begin
        #1;
        hist.push_back(bus.TX_OUT);
        bhist.push_back(bus.BUSY);
    end

    function automatic logic [31:0] slice(input int s, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = hist[s + i];
        return r;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        @(negedge clk);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    // Called at the negedge showing the start bit; checks the whole frame and the idle cycle after it.
    task automatic frame_check(input string name, input int n, input logic [31:0] exp_bits);
        int s;
        int bc;
        s = hist.size() - 1;
        repeat (n) @(negedge clk);
        bc = 0;
        for (int i = 0; i < n; i++) bc += int'(bhist[s + i]);
        chk({name, "_bits"}, slice(s, n), exp_bits);
        chk({name, "_busy_cycles"}, bc, n);
        chk({name, "_busy_before"}, bhist[s - 1], 1'b0);
        chk({name, "_busy_after"}, bhist[s + n], 1'b0);
        chk({name, "_line_after"}, hist[s + n], 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.BUSY !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_in_time", n < 200, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst            = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx_out", bus.TX_OUT, 1'b1);
        chk("reset_busy", bus.BUSY, 1'b0);
        chk("reset_rdy", bus.RDY, 1'b1);
        rst = 1'b0;

        send(8'hA5, 1'b0, 1'b0);
        frame_check("a5_nopar", 10, 32'b1101001010);
        send(8'hA5, 1'b1, 1'b0);
        frame_check("a5_even", 11, 32'b10101001010);
        send(8'hA5, 1'b1, 1'b1);
        frame_check("a5_odd", 11, 32'b11101001010);
        send(8'h00, 1'b1, 1'b1);
        frame_check("00_odd", 11, 32'b11000000000);

        // Requests during DATA and during STOP.
        send(8'h3C, 1'b0, 1'b0);
        s = hist.size() - 1;
        repeat (2) @(negedge clk);
        bus.P_DATA = 8'hFF;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        repeat (6) @(negedge clk);
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
`ifndef UART_TX_HOLD_REG_EN
        chk("3c_bits", slice(s, 10), 32'b1001111000);
        chk("3c_line_after", hist[s + 10], 1'b1);
        chk("3c_busy_after", bhist[s + 10], 1'b0);
        repeat (2) @(negedge clk);
        chk("3c_still_idle", bus.BUSY, 1'b0);
`endif
        wait_idle();

        // Inputs change right after acceptance; frame must keep the latched values.
        send(8'h5A, 1'b1, 1'b0);
        bus.P_DATA  = 8'hFF;
        bus.PAR_TYP = 1'b1;
        frame_check("5a_latched", 11, 32'b10010110100);

        // Reset while data bit 3 is on the line.
        send(8'hFF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_tx_out", bus.TX_OUT, 1'b1);
        chk("midreset_busy", bus.BUSY, 1'b0);
        send(8'h81, 1'b0, 1'b0);
        frame_check("81_after_reset", 10, 32'b1100000010);

`ifdef UART_TX_HOLD_REG_EN
        send(8'h12, 1'b0, 1'b0);
        s = hist.size() - 1;
        send(8'h34, 1'b0, 1'b0);
        chk("hold_rdy_low", bus.RDY, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        chk("hold_b2b_bits", slice(s, 20), {12'h0, 10'b1001101000, 10'b1000100100});
        chk("hold_line_after", hist[s + 20], 1'b1);
        chk("hold_busy_after", bhist[s + 20], 1'b0);
        wait_idle();
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
